chan_arb_mux: RTL and testbench

CHAN_ARB_MUX -- requirements
Module: chan_arb_mux

---
 rtl/chan_arb_mux.sv | 97 +++++++++
 tb/tb_chan_arb_mux.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/chan_arb_mux.sv
// Round-robin N-channel arbiter feeding a single registered output slot.
// Optional CHAN_ARB_MUX_LOCK_EN adds a 'lock' input that pins the grant to the channel in out_sel.
module chan_arb_mux #(
  parameter int W    = 4,
  parameter int N    = 4,
  parameter int SELW = 2
) (
  input  logic           clk,
  input  logic           rst_n,
`ifdef CHAN_ARB_MUX_LOCK_EN
  input  logic           lock,
`endif
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
  output logic [W-1:0]   out_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [SELW-1:0] out_sel
);

  logic [W-1:0]    data_q, data_d;
  logic [SELW-1:0] sel_q, sel_d;
  logic [SELW-1:0] last_q, last_d;
  logic            valid_q, valid_d;

  logic            load_en;
  logic            found;
  logic            transfer;
  logic [SELW-1:0] grant;
  int              idx;

  assign load_en = !valid_q | out_ready;

  // Scan upward from the channel after the last winner. The first hit wins.
  always_comb begin
    found = 1'b0;
    grant = '0;
    idx   = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last_q) + k) % N;
      if (!found && in_valid[idx]) begin
        found = 1'b1;
        grant = idx[SELW-1:0];
      end
    end
`ifdef CHAN_ARB_MUX_LOCK_EN
    // While locked, only the channel currently held may be offered a slot.
    if (lock && valid_q) begin
      grant = sel_q;
      found = |in_valid;
    end
`endif
  end

  always_comb begin
    in_ready = '0;
    if (rst_n && load_en && found) in_ready[grant] = 1'b1;
  end

  assign transfer = |(in_valid & in_ready);

  always_comb begin
    data_d  = data_q;
    sel_d   = sel_q;
    last_d  = last_q;
    valid_d = valid_q;
    if (transfer) begin
      data_d  = in_data[int'(grant)*W +: W];
      sel_d   = grant;
      last_d  = grant;
      valid_d = 1'b1;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  // Reset leaves last at N-1 so the first scan begins at channel 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      sel_q   <= '0;
      last_q  <= SELW'(N - 1);
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      valid_q <= valid_d;
    end
  end

  assign out_data  = data_q;
  assign out_sel   = sel_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_chan_arb_mux.sv
// Directed bench for chan_arb_mux: default N=4/W=4 plus N=2/W=1 and N=16/W=8 sweep instances.
// Lock scenarios compile in only when CHAN_ARB_MUX_LOCK_EN is defined.
module tb_chan_arb_mux;

  logic        clk;
  logic        rst_n;
  logic        out_ready;
  logic [15:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [3:0]  out_data;
  logic        out_valid;
  logic [1:0]  out_sel;
`ifdef CHAN_ARB_MUX_LOCK_EN
  logic        lock;
`endif

  logic [1:0]   in_data2, in_valid2, in_ready2;
  logic [0:0]   out_data2, out_sel2;
  logic         out_valid2;
  logic [127:0] in_data16;
  logic [15:0]  in_valid16, in_ready16;
  logic [7:0]   out_data16;
  logic [3:0]   out_sel16;
  logic         out_valid16;

  int errors;
  int checks;

  chan_arb_mux #(.W(4), .N(4), .SELW(2)) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef CHAN_ARB_MUX_LOCK_EN
    .lock(lock),
`endif
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_sel(out_sel)
  );

  chan_arb_mux #(.W(1), .N(2), .SELW(1)) dut2 (
    .clk(clk), .rst_n(rst_n),
`ifdef CHAN_ARB_MUX_LOCK_EN
    .lock(1'b0),
`endif
    .in_data(in_data2), .in_valid(in_valid2), .in_ready(in_ready2),
    .out_data(out_data2), .out_valid(out_valid2), .out_ready(out_ready), .out_sel(out_sel2)
  );

  chan_arb_mux #(.W(8), .N(16), .SELW(4)) dut16 (
    .clk(clk), .rst_n(rst_n),
`ifdef CHAN_ARB_MUX_LOCK_EN
    .lock(1'b0),
`endif
    .in_data(in_data16), .in_valid(in_valid16), .in_ready(in_ready16),
    .out_data(out_data16), .out_valid(out_valid16), .out_ready(out_ready), .out_sel(out_sel16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Advance one edge and check the beat that lands in the output slot.
  task automatic applyStimulus(input string tag, input logic [1:0] expSel, input logic [3:0] expData);
    @(posedge clk);
    #1;
    checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
    checkOutput({tag, "_sel"}, 32'(out_sel), 32'(expSel));
    checkOutput({tag, "_data"}, 32'(out_data), 32'(expData));
  endtask

  initial begin
    errors     = 0;
    checks     = 0;
    rst_n      = 1'b0;
    out_ready  = 1'b1;
    in_valid   = 4'b0000;
    in_data    = {4'h4, 4'h3, 4'h2, 4'h1};
    in_valid2  = 2'b00;
    in_data2   = 2'b01;
    in_valid16 = '0;
    for (int i = 0; i < 16; i++) in_data16[i*8 +: 8] = 8'(i * 3 + 1);
`ifdef CHAN_ARB_MUX_LOCK_EN
    lock = 1'b0;
`endif

    #2;
    checkOutput("rst_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_sel", 32'(out_sel), 32'd0);
    checkOutput("rst_data", 32'(out_data), 32'd0);
    in_valid = 4'b1111;
    #1;
    checkOutput("rst_ready", 32'(in_ready), 32'd0);

    // Release mid-cycle; round-robin with all channels valid
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("rr_ready0", 32'(in_ready), 32'b0001);
    applyStimulus("rr0", 2'd0, 4'h1);
    checkOutput("rr_ready1", 32'(in_ready), 32'b0010);
    applyStimulus("rr1", 2'd1, 4'h2);
    applyStimulus("rr2", 2'd2, 4'h3);
    applyStimulus("rr3", 2'd3, 4'h4);
    applyStimulus("rr4", 2'd0, 4'h1);
    applyStimulus("rr5", 2'd1, 4'h2);
    applyStimulus("rr6", 2'd2, 4'h3);

    // Backpressure holds the slot at 0x3 for three cycles
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checkOutput("bp_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      checkOutput("bp_data", 32'(out_data), 32'h3);
      checkOutput("bp_sel", 32'(out_sel), 32'd2);
      checkOutput("bp_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    applyStimulus("bp_next", 2'd3, 4'h4);

    // Async reset mid-cycle with a beat held
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_valid", 32'(out_valid), 32'd0);
    checkOutput("arst_sel", 32'(out_sel), 32'd0);
    checkOutput("arst_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Sparse requesters 1 and 3, scan starts at channel 0
    in_valid = 4'b1010;
    #1;
    checkOutput("sp_ready", 32'(in_ready), 32'b0010);
    applyStimulus("sp0", 2'd1, 4'h2);
    applyStimulus("sp1", 2'd3, 4'h4);
    applyStimulus("sp2", 2'd1, 4'h2);
    in_valid = 4'b0000;
    @(posedge clk);
    #1;
    checkOutput("drain_valid", 32'(out_valid), 32'd0);
    checkOutput("drain_sel", 32'(out_sel), 32'd1);
    checkOutput("drain_data", 32'(out_data), 32'h2);

    // Single continuous requester wins every cycle
    in_valid = 4'b0100;
    applyStimulus("one0", 2'd2, 4'h3);
    applyStimulus("one1", 2'd2, 4'h3);
    applyStimulus("one2", 2'd2, 4'h3);
    in_valid = 4'b0000;

`ifdef CHAN_ARB_MUX_LOCK_EN
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    in_valid = 4'b0101;
    applyStimulus("lk_a", 2'd0, 4'h1);
    applyStimulus("lk_b", 2'd2, 4'h3);
    lock = 1'b1;
    applyStimulus("lk0", 2'd2, 4'h3);
    applyStimulus("lk1", 2'd2, 4'h3);
    applyStimulus("lk2", 2'd2, 4'h3);
    lock = 1'b0;
    applyStimulus("lk_rel", 2'd0, 4'h1);
    in_valid = 4'b0000;
`endif

    // Parameter sweep: N=2/W=1 and N=16/W=8 all valid
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    in_valid2  = 2'b11;
    in_valid16 = 16'hFFFF;
    for (int k = 0; k < 17; k++) begin
      @(posedge clk);
      #1;
      checkOutput("sw2_sel", 32'(out_sel2), 32'(k % 2));
      checkOutput("sw2_data", 32'(out_data2), (k % 2 == 0) ? 32'd1 : 32'd0);
      checkOutput("sw16_sel", 32'(out_sel16), 32'(k % 16));
      checkOutput("sw16_data", 32'(out_data16), 32'((k % 16) * 3 + 1));
    end
    in_valid2  = 2'b00;
    in_valid16 = '0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
